// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: result-select encodings,
// load funct3 codes and the controller state encoding.
package wb_pkg;

  // Result select carried with each retiring instruction.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  // RV32I load width/sign encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback controller states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_COMMIT
  } state_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: combinational extraction and sign/zero extension of load data
// from a 32-bit memory word. Flags funct3 codes that are not loads.
// Build option WB_MISALIGN_TRAP_EN adds the misaligned output.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        illegal
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte and half; the half uses a[1] only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    byte_v = word[7:0];
    case (a)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = a[1] ? word[31:16] : word[15:0];
  end

  // Extend according to width/sign; anything not a load is illegal.
  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data = {24'b0, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LHU:  data = {16'b0, half_v};
      F3_LW:   data = word;
      default: illegal = 1'b1;
    endcase
  end

`ifdef WB_MISALIGN_TRAP_EN
  // Halves must be 2-byte aligned, words 4-byte aligned.
  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: misaligned = a[0];
      F3_LW:         misaligned = (a != 2'd0);
      default:       misaligned = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: last stage of the RV32I core. Selects ALU result, PC+4 or
// aligned load data and drives the register-file write port for one cycle.
// Loads wait up to MEM_TIMEOUT cycles for the memory response.
// Build option WB_MISALIGN_TRAP_EN: trap misaligned LH/LHU/LW on a misalign
// pulse instead of writing.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16  // must be >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] d,
  output logic [4:0]  rd,
  output logic        we_d,
  output logic        busy,
  output logic        err
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Operands a pending load still needs after the handshake.
  logic [4:0]       cap_rd_q, cap_rd_d;
  logic [1:0]       cap_addr_q, cap_addr_d;
  logic [2:0]       cap_f3_q, cap_f3_d;

  // Registered register-file write port and status pulses.
  logic [31:0]      wr_data_q, wr_data_d;
  logic [4:0]       wr_rd_q, wr_rd_d;
  logic             wr_en_q, wr_en_d;
  logic             err_q, err_d;
`ifdef WB_MISALIGN_TRAP_EN
  logic             mis_q, mis_d;
  logic             la_misaligned;
`endif

  logic [31:0]      la_data;
  logic             la_illegal;

  load_align u_load_align (
    .word    (mem_rdata),
    .a       (cap_addr_q),
    .funct3  (cap_f3_q),
    .data    (la_data),
    .illegal (la_illegal)
`ifdef WB_MISALIGN_TRAP_EN
    ,
    .misaligned (la_misaligned)
`endif
  );

  // Next-state and next-output logic for the writeback controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_rd_d   = cap_rd_q;
    cap_addr_d = cap_addr_q;
    cap_f3_d   = cap_f3_q;
    wr_data_d  = wr_data_q;
    wr_rd_d    = wr_rd_q;
    wr_en_d    = 1'b0;
    err_d      = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
    mis_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cap_rd_d   = in_rd;
          cap_addr_d = in_alu_result[1:0];
          cap_f3_d   = in_funct3;
          case (wb_sel_e'(in_wb_sel))
            WB_LOAD: begin
              state_d = S_WAIT_MEM;
              cnt_d   = '0;
            end
            WB_ALU: begin
              state_d   = S_COMMIT;
              wr_data_d = in_alu_result;
              wr_rd_d   = in_rd;
              wr_en_d   = (in_rd != 5'd0);
            end
            WB_PC4: begin
              state_d   = S_COMMIT;
              wr_data_d = in_pc_plus4;
              wr_rd_d   = in_rd;
              wr_en_d   = (in_rd != 5'd0);
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_WAIT_MEM: begin
        // A response in the final counted cycle still beats the timeout.
        if (mem_rvalid) begin
          if (la_illegal) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
`ifdef WB_MISALIGN_TRAP_EN
          else if (la_misaligned) begin
            mis_d   = 1'b1;
            state_d = S_IDLE;
          end
`endif
          else begin
            state_d   = S_COMMIT;
            wr_data_d = la_data;
            wr_rd_d   = cap_rd_q;
            wr_en_d   = (cap_rd_q != 5'd0);
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_COMMIT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State, captured operands and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge regardless of statement order.
    if (rst) begin
      // NOTE: reset clears every register here, including the captured
      // operands, so no stale load state survives an abandoned transaction.
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_rd_q   <= '0;
      cap_addr_q <= '0;
      cap_f3_q   <= '0;
      wr_data_q  <= '0;
      wr_rd_q    <= '0;
      wr_en_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_rd_q   <= cap_rd_d;
      cap_addr_q <= cap_addr_d;
      cap_f3_q   <= cap_f3_d;
      wr_data_q  <= wr_data_d;
      wr_rd_q    <= wr_rd_d;
      wr_en_q    <= wr_en_d;
      err_q      <= err_d;
`ifdef WB_MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign d        = wr_data_q;
  assign rd       = wr_rd_q;
  assign we_d     = wr_en_q;
  assign err      = err_q;
`ifdef WB_MISALIGN_TRAP_EN
  assign misalign = mis_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed cases plus randomized traffic.
// Expected register writes / error pulses (with their cycle) are queued at
// issue time and popped by an independent monitor.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int T = 16;  // MEM_TIMEOUT under test

  localparam int K_WRITE = 0;
  localparam int K_ERR   = 1;
  localparam int K_MIS   = 2;
  localparam int K_BAD   = 3;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] d;
  logic [4:0]  rd;
  logic        we_d;
  logic        busy;
  logic        err;
  logic        misalign;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  writeback_unit #(.MEM_TIMEOUT(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_funct3     (in_funct3),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .d             (d),
    .rd            (rd),
    .we_d          (we_d),
    .busy          (busy),
    .err           (err)
`ifdef WB_MISALIGN_TRAP_EN
    ,
    .misalign      (misalign)
`endif
  );

`ifndef WB_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load semantics computed arithmetically from the ISA rules.
  function automatic void model_load(input logic [31:0] w, input logic [1:0] a,
                                     input logic [2:0] f3, output int kind,
                                     output logic [31:0] v);
    int unsigned b, h, ai;
    ai   = int'(a);
    b    = (w >> (8 * ai)) & 32'hFF;
    h    = (w >> (16 * (ai / 2))) & 32'hFFFF;
    kind = K_WRITE;
    v    = '0;
    case (f3)
      3'd0:    v = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    v = b;
      3'd1:    v = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    v = h;
      3'd2:    v = w;
      default: kind = K_ERR;
    endcase
`ifdef WB_MISALIGN_TRAP_EN
    if (kind == K_WRITE &&
        (((f3 == 3'd1 || f3 == 3'd5) && (ai % 2) == 1) || (f3 == 3'd2 && ai != 0)))
      kind = K_MIS;
`endif
  endfunction

  function automatic void push(input int kind, input logic [4:0] r, input logic [31:0] v, input int c);
    exp_t e;
    e.kind = kind;
    e.rd   = r;
    e.d    = v;
    e.cyc  = c;
    sb_q.push_back(e);
  endfunction

  // Monitor: every write or status pulse must match the next expectation.
  always @(negedge clk) begin
    if (!rst && (we_d || err || misalign)) begin
      int   got;
      exp_t e;
      if (we_d && !err && !misalign)      got = K_WRITE;
      else if (err && !we_d && !misalign) got = K_ERR;
      else if (misalign && !we_d && !err) got = K_MIS;
      else                                got = K_BAD;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: kind %0d rd %0d d 0x%08h at cycle %0d, none expected",
                 got, rd, d, cyc);
      end else begin
        e = sb_q.pop_front();
        check("event_kind", got, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (e.kind == K_WRITE) begin
          check("write_rd", rd, e.rd);
          check("write_data", d, e.d);
        end
      end
    end
  end

  // Wait (bounded) until the unit can accept; caller is 1 time unit past posedge.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready still 0 after %0d cycles", n);
    end
  endtask

  // Issue one instruction; for loads answer after k WAIT_MEM cycles
  // (k >= T means the response arrives too late).
  task automatic issue(input logic [4:0] r, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3, input logic [31:0] word,
                       input int k, input bit ovr, input logic [31:0] ovr_d);
    int          c0, kind;
    logic [31:0] v;
    wait_ready();
    c0 = cyc;
    case (sel)
      2'b00: if (r != 5'd0) push(K_WRITE, r, alu, c0 + 1);
      2'b10: if (r != 5'd0) push(K_WRITE, r, pc4, c0 + 1);
      2'b11: push(K_ERR, 5'd0, 32'd0, c0 + 1);
      default: begin
        if (k >= T) push(K_ERR, 5'd0, 32'd0, c0 + T + 1);
        else begin
          model_load(word, alu[1:0], f3, kind, v);
          if (ovr) v = ovr_d;
          if (kind != K_WRITE)  push(kind, 5'd0, 32'd0, c0 + k + 2);
          else if (r != 5'd0)   push(K_WRITE, r, v, c0 + k + 2);
        end
      end
    endcase
    mem_rvalid    = 1'b0;
    in_valid      = 1'b1;
    in_rd         = r;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
    in_funct3     = f3;
    @(posedge clk); #1;
    in_valid      = 1'b0;
    in_rd         = 5'($urandom);
    in_wb_sel     = 2'($urandom);
    in_alu_result = $urandom;
    in_funct3     = 3'($urandom);
    if (sel == 2'b01) begin
      repeat (k) begin
        mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      mem_rdata  = word;
      mem_rvalid = 1'b1;
      @(posedge clk); #1;
      // Optionally hold rvalid into the following (COMMIT/IDLE) cycle.
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      if (mem_rvalid) begin
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_alu_result = '0;
    in_pc_plus4 = '0; in_funct3 = '0; mem_rdata = '0; mem_rvalid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_we_d", we_d, 1'b0);
    check("reset_d", d, 32'd0);
    check("reset_rd", rd, 5'd0);
    check("reset_err", err, 1'b0);
    check("reset_misalign", misalign, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU write, then the single COMMIT cycle, then ready again.
    issue(5'd5, WB_ALU, 32'hDEAD_BEEF, 32'd0, 3'd0, 32'd0, 0, 1'b0, 32'd0);
    @(negedge clk);
    check("commit_in_ready", in_ready, 1'b0);
    check("commit_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("after_commit_in_ready", in_ready, 1'b1);

    // x0 write suppressed: COMMIT cycle with no write and no error.
    issue(5'd0, WB_PC4, 32'd0, 32'h104, 3'd0, 32'd0, 0, 1'b0, 32'd0);
    @(negedge clk);
    check("x0_busy", busy, 1'b1);
    check("x0_we_d", we_d, 1'b0);
    check("x0_err", err, 1'b0);
    @(posedge clk); #1;

    // Load alignment cases against fixed expectations.
    issue(5'd1, WB_LOAD, 32'h1000_0003, 32'd0, F3_LB,  32'h80FF_7F01, 2, 1'b1, 32'hFFFF_FF80);
    issue(5'd2, WB_LOAD, 32'h1000_0001, 32'd0, F3_LBU, 32'h80FF_7F01, 2, 1'b1, 32'h0000_007F);
    issue(5'd3, WB_LOAD, 32'h1000_0002, 32'd0, F3_LH,  32'h80FF_7F01, 2, 1'b1, 32'hFFFF_80FF);
    issue(5'd4, WB_LOAD, 32'h1000_0000, 32'd0, F3_LHU, 32'h80FF_7F01, 2, 1'b1, 32'h0000_7F01);
    issue(5'd6, WB_LOAD, 32'h1000_0000, 32'd0, F3_LW,  32'h80FF_7F01, 2, 1'b1, 32'h80FF_7F01);

    // Timeout with late rvalid; response in the last allowed cycle; response
    // in the error-pulse cycle.
    issue(5'd7, WB_LOAD, 32'h2000_0000, 32'd0, F3_LW, 32'h1234_5678, T + 1, 1'b0, 32'd0);
    issue(5'd8, WB_LOAD, 32'h2000_0000, 32'd0, F3_LW, 32'hCAFE_F00D, T - 1, 1'b0, 32'd0);
    issue(5'd9, WB_LOAD, 32'h2000_0000, 32'd0, F3_LW, 32'hCAFE_F00D, T, 1'b0, 32'd0);

    // Reserved select, illegal load funct3, misaligned word load.
    issue(5'd10, WB_RSVD, 32'h55, 32'h66, 3'd0, 32'd0, 0, 1'b0, 32'd0);
    issue(5'd11, WB_LOAD, 32'h3000_0000, 32'd0, 3'b011, 32'hAAAA_5555, 1, 1'b0, 32'd0);
`ifdef WB_MISALIGN_TRAP_EN
    issue(5'd12, WB_LOAD, 32'h3000_0002, 32'd0, F3_LW, 32'h80FF_7F01, 1, 1'b0, 32'd0);
`else
    issue(5'd12, WB_LOAD, 32'h3000_0002, 32'd0, F3_LW, 32'h80FF_7F01, 1, 1'b1, 32'h80FF_7F01);
`endif

    // Reset in WAIT_MEM, then a stray response in IDLE.
    wait_ready();
    in_valid = 1'b1; in_wb_sel = WB_LOAD; in_rd = 5'd13; in_funct3 = F3_LW;
    in_alu_result = 32'h4000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rstload_we_d", we_d, 1'b0);
    check("rstload_busy", busy, 1'b0);
    check("rstload_d", d, 32'd0);
    check("rstload_rd", rd, 5'd0);
    check("rstload_err", err, 1'b0);
    check("rstload_misalign", misalign, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      int          r, k;
      logic [1:0]  sel;
      logic [4:0]  rdi;
      r   = $urandom_range(0, 9);
      sel = (r < 3) ? WB_ALU : (r < 7) ? WB_LOAD : (r < 9) ? WB_PC4 : WB_RSVD;
      rdi = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      k   = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, 5);
      issue(rdi, sel, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom, k, 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        // Stray response while IDLE or COMMIT must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
      end
    end

    repeat (T + 8) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage of the RV32I core. It sits directly upstream of the register file and drives its write port (d, rd, we_d).
- Accepts one retiring instruction at a time. Selects the ALU result, PC+4 or load data.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends it.
- Commits one register write per instruction. Writes to x0 are suppressed; memory timeouts and illegal encodings are flagged.

Parameters:
- MEM_TIMEOUT, 16: max cycles spent in WAIT_MEM before abandoning a load; must be >= 2. The counter width is derived as clog2(MEM_TIMEOUT)+1.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  unit can accept; high only in IDLE
- in_rd  in  5  destination register
- in_wb_sel  in  2  result select: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved
- in_alu_result  in  32  ALU result; for loads, the byte address
- in_pc_plus4  in  32  link value for JAL/JALR
- in_funct3  in  3  load width/sign
- mem_rdata  in  32  data-memory read word
- mem_rvalid  in  1  mem_rdata valid this cycle
- d  out  32  register-file write data
- rd  out  5  register-file write index
- we_d  out  1  register-file write enable
- busy  out  1  high when not in IDLE
- err  out  1  one-cycle pulse: timeout, reserved wb_sel or illegal load funct3
- misalign  out  1  one-cycle pulse; exists only when WB_MISALIGN_TRAP_EN is defined

Behaviour:
- Reset: state=IDLE; d=0, rd=0, we_d=0, err=0, misalign=0, timeout counter=0. All captured operands are cleared.
- Reset during WAIT_MEM abandons the load with no write. A mem_rvalid arriving afterwards while in IDLE is ignored.
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).

States and transitions:
- IDLE: in_ready=1. A handshake (in_valid && in_ready) captures rd, wb_sel, alu_result, pc_plus4 and funct3.
  - wb_sel=01 -> WAIT_MEM, counter cleared.
  - wb_sel=00 or 10 -> COMMIT.
  - wb_sel=11 -> err pulses next cycle; stays in IDLE; no write.
- WAIT_MEM: the counter increments each cycle.
  - mem_rvalid=1: capture mem_rdata -> COMMIT.
  - Counter reaches MEM_TIMEOUT-1 with no rvalid: err pulse, -> IDLE, no write.
  - rvalid and timeout in the same cycle: rvalid wins.
- COMMIT: lasts exactly one cycle, then -> IDLE. A new instruction can be accepted on the next cycle.

Outputs:
- d, rd and we_d are registered and valid only in the COMMIT cycle.
- we_d = (rd != 0). d keeps its last value outside COMMIT.

Latency:
- ALU/PC+4: handshake in cycle N -> we_d in cycle N+1.
- Load: rvalid in cycle M -> we_d in cycle M+1.
- Maximum throughput is one non-load instruction every 2 cycles.

Load alignment, by funct3 with a = alu_result[1:0]:
- 000 LB: byte a, sign-extended.
- 100 LBU: byte a, zero-extended.
- 001 LH: half a[1], sign-extended.
- 101 LHU: half a[1], zero-extended.
- 010 LW: full word.
- 011, 110, 111: err pulse on the rvalid cycle, no write, -> IDLE.

Other rules:
- mem_rvalid is ignored in IDLE and COMMIT.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned loads (LH/LHU with a[0]=1; LW with a!=0) pulse misalign on the rvalid cycle, perform no write and return to IDLE.
  - The misalign port exists.
- Undefined:
  - No misalign port.
  - Misaligned loads ignore the excess low address bits (LH uses a[1] only; LW ignores a) and write normally.

Decomposition:
- Shared package wb_pkg:
  - wb_sel encodings (WB_ALU, WB_LOAD, WB_PC4, WB_RSVD).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - State enum (S_IDLE, S_WAIT_MEM, S_COMMIT).
- Sub-module load_align: combinational. Inputs are word, a and funct3; outputs are the extended data, an illegal flag and a misaligned flag.

Test Plan:
- ALU write: in_wb_sel=00, in_rd=5, in_alu_result=0xDEADBEEF -> next cycle we_d=1, rd=5, d=0xDEADBEEF; then in_ready=1.
- x0 suppression: in_wb_sel=10, in_rd=0, in_pc_plus4=0x104 -> COMMIT cycle has we_d=0 and no err.
- Loads: mem_rdata=0x80FF7F01, rvalid 3 cycles after accept:
  - LB a=3 -> d=0xFFFFFF80.
  - LBU a=1 -> d=0x0000007F.
  - LH a=2 -> d=0xFFFF80FF.
  - LHU a=0 -> d=0x00007F01.
  - LW -> d=0x80FF7F01.
- Timeout: accept a load and never assert rvalid -> err=1 for one cycle after MEM_TIMEOUT cycles, we_d never asserted, in_ready=1 afterwards. A late rvalid is ignored.
- Reset mid-load: rst=1 in WAIT_MEM, then rvalid=1 in the following IDLE -> we_d stays 0, busy=0, all outputs at reset values.
- Illegal encodings:
  - wb_sel=11 -> err pulse, no write.
  - LW with a=2 and WB_MISALIGN_TRAP_EN defined -> misalign pulse, no write.
  - Same stimulus with the macro undefined -> full word written.
